mod_counter_16_bit: RTL and testbench

MOD_COUNTER_16_BIT -- requirements
Module: mod_counter_16_bit

---
 rtl/mod_counter_16_bit.sv | 73 +++++++
 tb/tb_mod_counter_16_bit.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/mod_counter_16_bit.sv
// mod_counter_16_bit: start/stop/load modulo-M up counter with tri-stated outputs.
// Define MOD_COUNTER_LOAD_CLAMP_EN to clamp loaded values to M-1.
`default_nettype none

module mod_counter_16_bit (
   input  logic        Clk_In,
   input  logic        Reset_In,
   input  logic        Enable_In,
   input  logic        Start_Counter_Command_In,
   input  logic        Stop_Counter_Command_In,
   input  logic        Load_Counter_Value_Command_In,
   input  logic [15:0] Preload_Counter_Value_In,
   input  logic [15:0] MOD_Value_In,
   output logic        Counter_Running_Flag_Out,
   output logic        Counter_Rollover_Flag_Out,
   output logic [15:0] Counter_Count_Out
);

   logic        running_q, running_d;
   logic        rollover_q, rollover_d;
   logic [15:0] count_q, count_d;
   logic [15:0] mod_m1;

   // Wraps modulo 2^16: M=0 behaves as modulus 65536.
   assign mod_m1 = MOD_Value_In - 16'd1;

   always_comb begin
      running_d  = running_q;
      rollover_d = 1'b0;
      count_d    = count_q;

      if (Start_Counter_Command_In) begin
         running_d = 1'b1;
      end else if (Stop_Counter_Command_In) begin
         running_d = 1'b0;
      end

      // Count action keys off the pre-edge running state.
      if (running_q) begin
         if (count_q >= mod_m1) begin
            count_d    = 16'd0;
            rollover_d = 1'b1;
         end else begin
            count_d = count_q + 16'd1;
         end
      end else if (Load_Counter_Value_Command_In) begin
`ifdef MOD_COUNTER_LOAD_CLAMP_EN
         count_d = (Preload_Counter_Value_In > mod_m1) ? mod_m1 : Preload_Counter_Value_In;
`else
         count_d = Preload_Counter_Value_In;
`endif
      end
   end

   always_ff @(posedge Clk_In or negedge Reset_In) begin
      if (!Reset_In) begin
         running_q  <= 1'b0;
         rollover_q <= 1'b0;
         count_q    <= 16'd0;
      end else begin
         running_q  <= running_d;
         rollover_q <= rollover_d;
         count_q    <= count_d;
      end
   end

   assign Counter_Running_Flag_Out  = Enable_In ? running_q  : 1'bz;
   assign Counter_Rollover_Flag_Out = Enable_In ? rollover_q : 1'bz;
   assign Counter_Count_Out         = Enable_In ? count_q    : 16'hzzzz;

endmodule

`default_nettype wire

// File: tb/tb_mod_counter_16_bit.sv
// Directed self-checking bench for mod_counter_16_bit.
`default_nettype none
`timescale 1ns/1ps

module tb_mod_counter_16_bit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        en;
   logic        start;
   logic        stop;
   logic        load;
   logic [15:0] preload;
   logic [15:0] mod_val;
   wire         run_o;
   wire         roll_o;
   wire  [15:0] cnt_o;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   mod_counter_16_bit dut (
      .Clk_In                        (clk),
      .Reset_In                      (rst_n),
      .Enable_In                     (en),
      .Start_Counter_Command_In      (start),
      .Stop_Counter_Command_In       (stop),
      .Load_Counter_Value_Command_In (load),
      .Preload_Counter_Value_In      (preload),
      .MOD_Value_In                  (mod_val),
      .Counter_Running_Flag_Out      (run_o),
      .Counter_Rollover_Flag_Out     (roll_o),
      .Counter_Count_Out             (cnt_o)
   );

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Advance one rising edge and sample 1ns later.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // A disabled output reads as Z; simulators that resolve undriven nets to 0 are also accepted.
   function automatic logic [15:0] z_norm(input logic [15:0] v);
      return (v === 16'hzzzz || v === 16'h0000) ? 16'h0000 : v;
   endfunction

   function automatic logic [15:0] z_norm1(input logic v);
      return (v === 1'bz || v === 1'b0) ? 16'h0000 : {15'd0, v};
   endfunction

   logic [15:0] exp_cnt;
   logic [15:0] exp_load15;

   initial begin
      rst_n = 1'b0; en = 1'b1; start = 1'b0; stop = 1'b0; load = 1'b0;
      preload = 16'd0; mod_val = 16'd10;
`ifdef MOD_COUNTER_LOAD_CLAMP_EN
      exp_load15 = 16'd9;
`else
      exp_load15 = 16'd15;
`endif
      #12;
      check("rst_run",  {15'd0, run_o},  16'd0);
      check("rst_roll", {15'd0, roll_o}, 16'd0);
      check("rst_cnt",  cnt_o,           16'h0000);
      en = 1'b0; #1;
      check("rst_z_cnt",  (cnt_o  === 16'hzzzz) ? 16'h0 : 16'h1, 16'h0);
      en = 1'b1;
      #2 rst_n = 1'b1;

      // Start pulse: running rises, count moves one edge later.
      @(posedge clk); #1;
      start = 1'b1;
      tick();
      start = 1'b0;
      check("start_run", {15'd0, run_o}, 16'd1);
      check("start_cnt", cnt_o, 16'd0);
      exp_cnt = 16'd0;
      for (int i = 0; i < 15; i++) begin
         tick();
         exp_cnt = (exp_cnt == 16'd9) ? 16'd0 : exp_cnt + 16'd1;
         check("run_cnt",  cnt_o, exp_cnt);
         check("run_roll", {15'd0, roll_o}, (exp_cnt == 16'd0) ? 16'd1 : 16'd0);
      end
      // exp_cnt now 5

      stop = 1'b1;
      tick();
      stop = 1'b0;
      check("stop_run", {15'd0, run_o}, 16'd0);
      check("stop_cnt", cnt_o, 16'd6);
      tick();
      check("stop_hold", cnt_o, 16'd6);
      check("stop_roll", {15'd0, roll_o}, 16'd0);

      // Reset, load 5, start.
      rst_n = 1'b0; #2;
      check("rst2_cnt", cnt_o, 16'd0);
      rst_n = 1'b1;
      load = 1'b1; preload = 16'd5;
      tick();
      load = 1'b0;
      check("load5", cnt_o, 16'd5);
      start = 1'b1;
      tick();
      start = 1'b0;
      check("load5_start", cnt_o, 16'd5);
      tick(); check("l_6", cnt_o, 16'd6);
      tick(); check("l_7", cnt_o, 16'd7);
      tick(); check("l_8", cnt_o, 16'd8);
      tick(); check("l_9", cnt_o, 16'd9);
      tick(); check("l_0", cnt_o, 16'd0);
      check("l_0_roll", {15'd0, roll_o}, 16'd1);
      load = 1'b1; preload = 16'd3;
      tick();
      load = 1'b0;
      check("load_ignored", cnt_o, 16'd1);
      check("l_1_roll", {15'd0, roll_o}, 16'd0);

      // Out-of-range preload.
      stop = 1'b1;
      tick();
      stop = 1'b0;
      check("stop2_cnt", cnt_o, 16'd2);
      load = 1'b1; preload = 16'd15;
      tick();
      load = 1'b0;
      check("load15", cnt_o, exp_load15);
      start = 1'b1;
      tick();
      start = 1'b0;
      check("load15_hold", cnt_o, exp_load15);
      tick();
      check("load15_wrap", cnt_o, 16'd0);
      check("load15_roll", {15'd0, roll_o}, 16'd1);

      // Outputs disabled for three edges while counting continues.
      en = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("dis_cnt", z_norm(cnt_o), 16'd0);
         check("dis_run", z_norm1(run_o), 16'd0);
      end
      en = 1'b1; #1;
      check("reen_cnt", cnt_o, 16'd3);
      check("reen_run", {15'd0, run_o}, 16'd1);

      // M=1 pins count at 0 with rollover every cycle; M=0 is modulus 65536.
      mod_val = 16'd1;
      tick();
      check("m1_cnt", cnt_o, 16'd0);
      check("m1_roll", {15'd0, roll_o}, 16'd1);
      tick();
      check("m1_cnt2", cnt_o, 16'd0);
      check("m1_roll2", {15'd0, roll_o}, 16'd1);
      mod_val = 16'd0;
      tick();
      check("m0_cnt", cnt_o, 16'd1);
      check("m0_roll", {15'd0, roll_o}, 16'd0);

      // Asynchronous reset mid-cycle.
      #2 rst_n = 1'b0; #1;
      check("async_rst_cnt", cnt_o, 16'd0);
      check("async_rst_run", {15'd0, run_o}, 16'd0);
      rst_n = 1'b1;

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire
